feature_map_pingpong_buffer: RTL and testbench
==============================================

FEATURE_MAP_PINGPONG_BUFFER -- requirements
Module: feature_map_pingpong_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per channel sample.
REQ-002 The block SHALL have parameter CH_NUM, default 18, meaning channels per memory word; word width W = CH_NUM*DATA_WIDTH.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 13, meaning address bits per bank; bank depth D = 2**ADDR_WIDTH.
REQ-004 The block SHALL have port calc_clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port rstn, input, 1, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port conv_wr_data / conv_wr_addr / conv_wr_valid, inputs, W / ADDR_WIDTH / 1, the convolution write-back path.
REQ-007 The block SHALL have port ddr_wr_data / ddr_wr_addr / ddr_wr_valid, inputs, W / ADDR_WIDTH / 1, the width-converted DDR load path.
REQ-008 The block SHALL have port ddr_wr_ready, output, 1, DDR write accepted when valid & ready.
REQ-009 The block SHALL have port rd_en / rd_addr, inputs, 1 / ADDR_WIDTH, the read request.
REQ-010 The block SHALL have port rd_data / rd_valid, outputs, W / 1, the read response.
REQ-011 The block SHALL have port swap_req, input, 1, a level request to exchange banks.
REQ-012 The block SHALL have port swap_ack, output, 1, a one-cycle pulse when the swap completes.
REQ-013 The block SHALL have port wr_bank, output, 1, the bank index currently written; the read bank is ~wr_bank.
REQ-014 The block SHALL have port wr_count, output, ADDR_WIDTH+1, writes accepted into wr_bank since the last swap.
REQ-015 The block SHALL have port wr_err, output, 1, a sticky flag for a dropped conv write.

Function
REQ-016 The block SHALL hold two banks, each D x W, simple-dual-port; bank contents are not reset.
REQ-017 Write arbitration: conv_wr_valid has priority; ddr_wr_ready = (state==ACTIVE) & ~conv_wr_valid, combinational.
REQ-018 An accepted write (conv valid, or ddr valid&ready, in ACTIVE) SHALL store data at its address in wr_bank on the same edge.
REQ-019 wr_count SHALL increment by 1 per accepted write and saturate at D; address values do not affect the count.
REQ-020 Reads SHALL always target bank ~wr_bank: rd_en accepted in ACTIVE gives rd_valid=1 and rd_data exactly 2 cycles later (RAM register + output register), one response per request, in order, full throughput.
REQ-021 When rd_valid=0, rd_data SHALL hold its last value.
REQ-022 The FSM SHALL have states ACTIVE, DRAIN and SWAP.
REQ-023 ACTIVE SHALL go to DRAIN when swap_req=1.
REQ-024 DRAIN SHALL go to SWAP once the read pipeline is empty, i.e. no rd_en accepted in the previous 2 cycles; this takes at most 2 cycles in DRAIN.
REQ-025 SWAP SHALL go to ACTIVE after exactly 1 cycle.
REQ-026 In DRAIN and SWAP, rd_en is ignored and ddr_wr_ready=0.
REQ-027 A conv_wr_valid in DRAIN or SWAP SHALL be dropped, not written, and SHALL set wr_err, which stays set until reset.
REQ-028 On the SWAP cycle's clock edge, wr_bank SHALL toggle, wr_count SHALL clear to 0, and swap_ack SHALL be 1 for exactly that following cycle.
REQ-029 A write and a read in the same cycle to the same address SHALL not conflict, since they always target different banks.
REQ-030 swap_req held high after swap_ack SHALL start a new swap in the first ACTIVE cycle.
REQ-031 Addresses wrap naturally at D; no out-of-range check is required.

Reset
REQ-032 While rstn=0: state=ACTIVE, wr_bank=0, wr_count=0, wr_err=0, swap_ack=0, rd_valid=0, rd_data=0, read pipeline flushed.
REQ-033 These values SHALL apply asynchronously on rstn falling, including mid-read or mid-swap.
REQ-034 Operation SHALL resume on the first calc_clk edge after rstn rises.

Verification
REQ-035 Write, swap, read: DDR writes addr 0..3 with data k+1 -> wr_count=4; swap -> wr_bank=1, swap_ack one pulse; rd_en addr 0..3 -> rd_data 1..4 at +2 cycles, rd_valid contiguous.
REQ-036 Arbitration: conv and DDR valid in the same cycle, addr 5 -> ddr_wr_ready=0, conv data stored, DDR write stalls until conv_wr_valid=0.
REQ-037 Drain: rd_en on the cycle before swap_req -> swap_ack delayed until rd_valid has emitted; rd_en during DRAIN -> no rd_valid.
REQ-038 Drop: conv_wr_valid during DRAIN -> wr_err=1, target word unchanged after a second swap, wr_count unaffected.
REQ-039 Saturation: D+3 writes (ADDR_WIDTH=4) -> wr_count=16 and holds.
REQ-040 Async reset mid-read-burst -> rd_valid=0 and rd_data=0 immediately, wr_bank=0, no spurious rd_valid after release.

Source files
------------

// File: rtl/feature_map_pingpong_buffer.sv
// Two-bank ping-pong feature-map buffer: one bank takes conv/DDR writes while the other
// serves reads; a swap handshake drains the read pipeline before exchanging the banks.
module feature_map_pingpong_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CH_NUM     = 18,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                         calc_clk,
    input  logic                         rstn,
    input  logic [CH_NUM*DATA_WIDTH-1:0] conv_wr_data,
    input  logic [ADDR_WIDTH-1:0]        conv_wr_addr,
    input  logic                         conv_wr_valid,
    input  logic [CH_NUM*DATA_WIDTH-1:0] ddr_wr_data,
    input  logic [ADDR_WIDTH-1:0]        ddr_wr_addr,
    input  logic                         ddr_wr_valid,
    output logic                         ddr_wr_ready,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [CH_NUM*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         wr_bank,
    output logic [ADDR_WIDTH:0]          wr_count,
    output logic                         wr_err
);

    localparam int unsigned W = CH_NUM * DATA_WIDTH;
    localparam int unsigned D = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CntMax = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {StActive, StDrain, StSwap} state_e;

    state_e                state_q, state_d;
    logic                  active;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [W-1:0]          wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // Both banks live in one array; the MSB of the index selects the bank.
    logic [W-1:0]          mem [2*D];
    logic [W-1:0]          ram_q;
    logic                  ram_vld_q;
    logic [W-1:0]          rd_data_q;
    logic                  rd_valid_q;
    logic                  wr_bank_q;
    logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
    logic                  wr_err_q;
    logic                  swap_ack_q;

    always_comb begin
        active       = (state_q == StActive);
        ddr_wr_ready = active & ~conv_wr_valid;
        wr_acc       = active & (conv_wr_valid | ddr_wr_valid);
        wr_data      = conv_wr_valid ? conv_wr_data : ddr_wr_data;
        wr_addr      = conv_wr_valid ? conv_wr_addr : ddr_wr_addr;
        rd_acc       = active & rd_en;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StActive: if (swap_req) state_d = StDrain;
            // Only the RAM stage can still hold a read of the old bank here.
            StDrain:  if (!ram_vld_q) state_d = StSwap;
            StSwap:   state_d = StActive;
            default:  state_d = StActive;
        endcase
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (state_q == StSwap) begin
            wr_count_d = '0;
        end else if (wr_acc && (wr_count_q != CntMax)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    // Bank storage and RAM read register carry no reset.
    always_ff @(posedge calc_clk) begin
        if (wr_acc) mem[{wr_bank_q, wr_addr}] <= wr_data;
        if (rd_acc) ram_q <= mem[{~wr_bank_q, rd_addr}];
    end

    always_ff @(posedge calc_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StActive;
            ram_vld_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_bank_q  <= 1'b0;
            wr_count_q <= '0;
            wr_err_q   <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_vld_q  <= rd_acc;
            rd_valid_q <= ram_vld_q;
            if (ram_vld_q) rd_data_q <= ram_q;
            if (state_q == StSwap) wr_bank_q <= ~wr_bank_q;
            wr_count_q <= wr_count_d;
            wr_err_q   <= wr_err_q | (conv_wr_valid & ~active);
            swap_ack_q <= (state_q == StSwap);
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign swap_ack = swap_ack_q;
    assign wr_bank  = wr_bank_q;
    assign wr_count = wr_count_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_feature_map_pingpong_buffer.sv
// Bench for feature_map_pingpong_buffer: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-indexed reference model.
module tb_feature_map_pingpong_buffer;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int AW = 4;
    localparam int W  = DW * CH;
    localparam int D  = 1 << AW;

    logic          calc_clk = 1'b0;
    logic          rstn = 1'b0;
    logic [W-1:0]  conv_wr_data, ddr_wr_data, rd_data;
    logic [AW-1:0] conv_wr_addr, ddr_wr_addr, rd_addr;
    logic          conv_wr_valid, ddr_wr_valid, ddr_wr_ready;
    logic          rd_en, rd_valid, swap_req, swap_ack, wr_bank, wr_err;
    logic [AW:0]   wr_count;

    feature_map_pingpong_buffer #(
        .DATA_WIDTH(DW), .CH_NUM(CH), .ADDR_WIDTH(AW)
    ) dut (
        .calc_clk(calc_clk), .rstn(rstn),
        .conv_wr_data(conv_wr_data), .conv_wr_addr(conv_wr_addr), .conv_wr_valid(conv_wr_valid),
        .ddr_wr_data(ddr_wr_data), .ddr_wr_addr(ddr_wr_addr), .ddr_wr_valid(ddr_wr_valid),
        .ddr_wr_ready(ddr_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .swap_req(swap_req), .swap_ack(swap_ack), .wr_bank(wr_bank),
        .wr_count(wr_count), .wr_err(wr_err)
    );

    always #5 calc_clk = ~calc_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: phase 0 = accepting, 1 = draining, 2 = exchanging banks.
    typedef struct {
        int           due;
        logic [W-1:0] data;
    } rd_t;
    rd_t          rdq[$];
    int           m_phase, m_cnt, m_last_rd;
    logic         m_bank, m_err, m_ack, m_rv;
    logic [W-1:0] m_rd;
    logic [W-1:0] m_mem [2][D];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_last_rd = -10;
        m_bank = 1'b0; m_err = 1'b0; m_ack = 1'b0; m_rv = 1'b0; m_rd = '0;
        rdq.delete();
    endtask

    task automatic model_step();
        bit acc;
        int rb;
        acc = (m_phase == 0);
        rb  = m_bank ? 0 : 1;
        if (conv_wr_valid) begin
            if (acc) begin
                m_mem[m_bank][conv_wr_addr] = conv_wr_data;
                if (m_cnt < D) m_cnt++;
            end else begin
                m_err = 1'b1;
            end
        end else if (ddr_wr_valid && acc) begin
            m_mem[m_bank][ddr_wr_addr] = ddr_wr_data;
            if (m_cnt < D) m_cnt++;
        end
        if (rd_en && acc) begin
            rdq.push_back('{cyc + 2, m_mem[rb][rd_addr]});
            m_last_rd = cyc;
        end
        m_ack = 1'b0;
        case (m_phase)
            0: if (swap_req) m_phase = 1;
            1: if (m_last_rd != cyc - 1) m_phase = 2;
            default: begin
                m_bank = ~m_bank; m_cnt = 0; m_ack = 1'b1; m_phase = 0;
            end
        endcase
        cyc++;
        m_rv = 1'b0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            m_rv = 1'b1;
            m_rd = rdq[0].data;
            void'(rdq.pop_front());
        end
    endtask

    task automatic idle();
        conv_wr_valid = 0; conv_wr_addr = '0; conv_wr_data = '0;
        ddr_wr_valid = 0; ddr_wr_addr = '0; ddr_wr_data = '0;
        rd_en = 0; rd_addr = '0; swap_req = 0;
    endtask

    // Called one time unit after an active edge; returns one unit after the next one.
    task automatic tick();
        #1;
        chk("ddr_wr_ready", ddr_wr_ready, (m_phase == 0) && !conv_wr_valid);
        model_step();
        @(posedge calc_clk);
        #1;
        chk("rd_valid", rd_valid, m_rv);
        chk("rd_data", rd_data, m_rd);
        chk("wr_bank", wr_bank, m_bank);
        chk("wr_count", wr_count, m_cnt);
        chk("wr_err", wr_err, m_err);
        chk("swap_ack", swap_ack, m_ack);
    endtask

    task automatic do_swap();
        bit got;
        got = 0;
        swap_req = 1;
        tick();
        swap_req = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (swap_ack) got = 1;
        end
        chk("swap_done", got, 1);
    endtask

    task automatic async_reset();
        #2 rstn = 0;
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_wr_err", wr_err, 0);
        model_reset();
        idle();
        @(posedge calc_clk);
        #3 rstn = 1;
        @(posedge calc_clk);
        cyc++;
        #1;
    endtask

    typedef struct {
        logic          dv; logic [AW-1:0] da; logic [W-1:0] dd;
        logic          cv; logic [AW-1:0] ca; logic [W-1:0] cd;
        logic          re; logic [AW-1:0] ra; logic sw;
        logic          e_rdy; logic e_bank; int e_cnt; logic e_ack; logic e_rv; logic [W-1:0] e_rd;
    } vec_t;
    vec_t tbl[24];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sw_hold;
        int rv_cnt, rv_at, ack_at, cnt_before;

        tbl[0]  = '{1, 0, 16'h1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'h0};
        tbl[1]  = '{1, 1, 16'h2, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 16'h0};
        tbl[2]  = '{1, 2, 16'h3, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 16'h0};
        tbl[3]  = '{1, 3, 16'h4, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 16'h0};
        tbl[4]  = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 16'h0};
        tbl[5]  = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 16'h0};
        tbl[6]  = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0};
        tbl[7]  = '{0, 0, 16'h0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 16'h0};
        tbl[8]  = '{0, 0, 16'h0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 16'h1};
        tbl[9]  = '{0, 0, 16'h0, 0, 0, 0, 1, 2, 0, 1, 1, 0, 0, 1, 16'h2};
        tbl[10] = '{0, 0, 16'h0, 0, 0, 0, 1, 3, 0, 1, 1, 0, 0, 1, 16'h3};
        tbl[11] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 16'h4};
        tbl[12] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h4};
        tbl[13] = '{1, 6, 16'h55, 1, 5, 16'hAA, 0, 0, 0, 0, 1, 1, 0, 0, 16'h4};
        tbl[14] = '{1, 6, 16'h55, 1, 7, 16'hBB, 0, 0, 0, 0, 1, 2, 0, 0, 16'h4};
        tbl[15] = '{1, 6, 16'h55, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 16'h4};
        tbl[16] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0, 0, 16'h4};
        tbl[17] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 16'h4};
        tbl[18] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h4};
        tbl[19] = '{0, 0, 16'h0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 16'h4};
        tbl[20] = '{0, 0, 16'h0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 0, 1, 16'hAA};
        tbl[21] = '{0, 0, 16'h0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0, 1, 16'h55};
        tbl[22] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'hBB};
        tbl[23] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'hBB};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < D; a++) m_mem[b][a] = '0;
        idle();
        model_reset();
        #1;
        chk("por_rd_valid", rd_valid, 0);
        chk("por_rd_data", rd_data, 0);
        chk("por_wr_bank", wr_bank, 0);
        chk("por_wr_count", wr_count, 0);
        chk("por_ddr_wr_ready", ddr_wr_ready, 1);
        #20 rstn = 1;
        @(posedge calc_clk);
        #1;

        // Give every word of both banks a defined value.
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < D; a++) begin
                ddr_wr_valid = 1; ddr_wr_addr = AW'(a); ddr_wr_data = W'($urandom);
                tick();
            end
            idle();
            do_swap();
        end

        async_reset();

        for (int i = 0; i < 24; i++) begin
            ddr_wr_valid = tbl[i].dv; ddr_wr_addr = tbl[i].da; ddr_wr_data = tbl[i].dd;
            conv_wr_valid = tbl[i].cv; conv_wr_addr = tbl[i].ca; conv_wr_data = tbl[i].cd;
            rd_en = tbl[i].re; rd_addr = tbl[i].ra; swap_req = tbl[i].sw;
            #1;
            chk($sformatf("vec%0d_ready", i), ddr_wr_ready, tbl[i].e_rdy);
            tick();
            chk($sformatf("vec%0d_bank", i), wr_bank, tbl[i].e_bank);
            chk($sformatf("vec%0d_count", i), wr_count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_ack", i), swap_ack, tbl[i].e_ack);
            chk($sformatf("vec%0d_rv", i), rd_valid, tbl[i].e_rv);
            chk($sformatf("vec%0d_rd", i), rd_data, tbl[i].e_rd);
        end
        idle();

        // Drain: a read just before (or with) swap_req must emerge before swap_ack.
        for (int same = 0; same < 2; same++) begin
            rv_cnt = 0; rv_at = -1; ack_at = -1;
            rd_en = 1; rd_addr = 4'd2; swap_req = same[0];
            tick();
            if (rd_valid) begin rv_cnt++; rv_at = cyc; end
            rd_en = 0; swap_req = 1;
            if (same == 0) begin
                tick();
                if (rd_valid) begin rv_cnt++; rv_at = cyc; end
            end
            swap_req = 0; rd_en = 1; rd_addr = 4'd3;
            for (int i = 0; i < 8 && ack_at < 0; i++) begin
                tick();
                rd_en = 0;
                if (rd_valid) begin rv_cnt++; rv_at = cyc; end
                if (swap_ack) ack_at = cyc;
            end
            tick();
            if (rd_valid) rv_cnt++;
            chk("drain_rv_count", rv_cnt, 1);
            chk("drain_ack_seen", ack_at >= 0, 1);
            chk("drain_ack_after_rv", ack_at > rv_at, 1);
        end

        // Drop: a conv write while draining is lost and flags wr_err.
        chk("err_before_drop", wr_err, 0);
        ddr_wr_valid = 1; ddr_wr_addr = 4'd9; ddr_wr_data = 16'h0F0F;
        tick();
        idle();
        cnt_before = m_cnt;
        swap_req = 1;
        tick();
        swap_req = 0;
        conv_wr_valid = 1; conv_wr_addr = 4'd9; conv_wr_data = 16'h1234;
        tick();
        idle();
        chk("drop_wr_err", wr_err, 1);
        chk("drop_wr_count", wr_count, cnt_before);
        for (int i = 0; i < 6 && !swap_ack; i++) tick();
        rd_en = 1; rd_addr = 4'd9;
        tick();
        idle();
        tick();
        chk("drop_word_rv", rd_valid, 1);
        chk("drop_word_kept", rd_data, 16'h0F0F);
        do_swap();
        chk("drop_err_sticky", wr_err, 1);

        // Saturation at D accepted writes.
        for (int i = 0; i < D + 3; i++) begin
            ddr_wr_valid = 1; ddr_wr_addr = AW'(i); ddr_wr_data = W'($urandom);
            tick();
        end
        chk("sat_count", wr_count, D);
        conv_wr_valid = 1; conv_wr_addr = 4'd1; conv_wr_data = 16'hCAFE;
        tick();
        idle();
        tick();
        chk("sat_hold", wr_count, D);

        // Randomized traffic against the model.
        sw_hold = 0;
        for (int i = 0; i < 700; i++) begin
            if (sw_hold == 0 && $urandom_range(0, 24) == 0) sw_hold = $urandom_range(1, 6);
            swap_req = (sw_hold > 0);
            if (sw_hold > 0) sw_hold--;
            conv_wr_valid = ($urandom_range(0, 5) == 0);
            conv_wr_addr = AW'($urandom); conv_wr_data = W'($urandom);
            ddr_wr_valid = $urandom_range(0, 1);
            ddr_wr_addr = AW'($urandom); ddr_wr_data = W'($urandom);
            rd_en = $urandom_range(0, 1); rd_addr = AW'($urandom);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Async reset in the middle of a read burst.
        if (!m_bank) do_swap();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_addr = AW'(i);
            tick();
        end
        chk("burst_rv_before_rst", rd_valid, 1);
        async_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_rv", rd_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
